rf_write_arb: RTL and testbench
===============================

RF_WRITE_ARB -- requirements
Module: rf_write_arb

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock; the only clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 SHALL have ports wb_valid/wb_addr/wb_data (input, 1/5/32): the primary writeback (load or ALU result) for the instruction in WB.
REQ-003 SHALL have ports upd_valid/upd_addr/upd_data (input, 1/5/32): the base-register update from pre/post-increment memory ops, same instruction as wb.
REQ-004 SHALL have ports mc_valid/mc_addr/mc_data (input, 1/5/32) and mc_ready (output, 1): the multicycle-unit result; valid/ready handshake.
REQ-005 SHALL have ports wen0/waddr0/wdata0 and wen1/waddr1/wdata1 (output, 1/5/32 each): drive the two regfile write ports.
REQ-006 SHALL have ports raddr0/raddr1 (input, 5) and pend_hit0/pend_hit1 (output, 1): read-hazard query against buffered writes.
REQ-007 SHALL have port stall_out (output, 1): registered request to freeze the pipeline.

Function
REQ-008 SHALL hold a 4-entry FIFO of deferred writes {addr, data}, with the oldest entry at the head.
REQ-009 SHALL treat W/U as candidates only when stall_out=0 and the respective valid=1; the upstream keeps wb_valid/upd_valid low while stall_out=1.
REQ-010 SHALL drop U (complete it, no write) when W is also a candidate and upd_addr==wb_addr, so the load takes precedence.
REQ-011 SHALL complete any candidate with addr 0 without asserting a write enable.
REQ-012 SHALL order the surviving candidates by age: FIFO entries oldest first, then W, then U, then M.
REQ-013 SHALL grant the first candidate in that order to port 0 and the second to port 1, strictly in order with no skipping.
REQ-014 SHALL withhold the port-1 grant when its addr equals the port-0 addr; only one write occurs that cycle.
REQ-015 SHALL append the ungranted W and U to the FIFO in age order in the same cycle, then M if space remains.
REQ-016 SHALL compute mc_ready combinationally: 1 iff M is granted a port or fits in the FIFO after W/U; M transfers only on mc_valid&&mc_ready.
REQ-017 SHALL drive the write-port outputs combinationally; wen0/wen1 are 0 when the port is not granted.
REQ-018 SHALL update the FIFO on the rising clk edge: pop the granted entries, then push the deferred candidates.
REQ-019 SHALL assert pend_hit<n> combinationally iff raddr<n>!=0 and raddr<n> matches any valid FIFO entry, ignoring same-cycle grants.
REQ-020 SHALL register stall_out = (post-edge FIFO count >= 2), guaranteeing room for W and U on every non-stalled cycle.
REQ-021 SHALL keep FIFO overflow unreachable; the bench asserts count <= 4 at all times.

Reset
REQ-022 SHALL clear all FIFO valid bits immediately on rst_n low, regardless of clk.
REQ-023 SHALL force count=0 and stall_out=0 on rst_n low, regardless of clk.
REQ-024 SHALL discard any write in flight at reset, with no port write during or after it.
REQ-025 SHALL hold wen0=wen1=0, pend_hit0/1=0 and mc_ready=0 while rst_n is low.

Configuration
REQ-026 SHALL, when RF_WRITE_ARB_FWD_EN is defined, add outputs fwd_data0/fwd_data1 (32): data of the youngest FIFO entry matching raddr<n>, valid when pend_hit<n>=1, else 0.
REQ-027 SHALL, when RF_WRITE_ARB_FWD_EN is undefined, omit the fwd_data ports; all other behaviour is identical.

Verification
REQ-028 SHALL cover: W(r5,0x11) + U(r6,0x22), FIFO empty -> wen0 r5=0x11, wen1 r6=0x22, FIFO stays empty, stall_out=0.
REQ-029 SHALL cover: W(r7,0xAA) + U(r7,0xBB) -> only wen0 r7=0xAA, wen1=0, U dropped.
REQ-030 SHALL cover: W(r4,1), U(r9,2), M(r3,3) all valid together -> M deferred (mc_ready=1, pushed); next cycle port0 r3=3, and pend_hit0=1 when raddr0=3 in between.
REQ-031 SHALL cover: FIFO count 2 -> stall_out=1 next cycle; W/U ignored while stalled; FIFO drains 2 per cycle, stall_out falls when count<2.
REQ-032 SHALL cover: FIFO {r8,r8} same addr -> one write per cycle, in order; final r8 = the younger data.
REQ-033 SHALL cover: rst_n low mid-drain with 3 entries -> immediate wen0=wen1=0 and stall_out=0; no writes after release; with RF_WRITE_ARB_FWD_EN, a fwd_data0 check returns the youngest match.

Source files
------------

// File: rtl/rf_write_arb.sv
// Merges the writeback result (W), the base-register update (U) and the
// multicycle result (M) onto the two regfile write ports. Writes that cannot
// be granted are parked in a 4-entry age-ordered FIFO.
// Latency: grants are combinational in the same cycle; deferred writes retire
// oldest first, up to two per cycle.
// Backpressure: mc_ready is combinational. stall_out is registered and rises
// when two or more writes are still parked.
//
// Optional feature: define RF_WRITE_ARB_FWD_EN to add fwd_data0/fwd_data1.
// Each returns the data of the youngest parked write to raddr<n>.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wb_valid/addr/data            primary writeback for the instruction in WB
//   upd_valid/addr/data           base-register update, same instruction as W
//   mc_valid/addr/data, mc_ready  multicycle result, valid/ready handshake
//   wen0/waddr0/wdata0            regfile write port 0 (oldest grant)
//   wen1/waddr1/wdata1            regfile write port 1
//   raddr0/1, pend_hit0/1         read-hazard query against parked writes
//   fwd_data0/1                   (RF_WRITE_ARB_FWD_EN) forwarded parked data
//   stall_out                     registered pipeline freeze request
module rf_write_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        upd_valid,
  input  logic [4:0]  upd_addr,
  input  logic [31:0] upd_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_addr,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        wen0,
  output logic [4:0]  waddr0,
  output logic [31:0] wdata0,
  output logic        wen1,
  output logic [4:0]  waddr1,
  output logic [31:0] wdata1,
  input  logic [4:0]  raddr0,
  input  logic [4:0]  raddr1,
  output logic        pend_hit0,
  output logic        pend_hit1,
`ifdef RF_WRITE_ARB_FWD_EN
  output logic [31:0] fwd_data0,
  output logic [31:0] fwd_data1,
`endif
  output logic        stall_out
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  localparam logic [1:0] SRC_FIFO = 2'd0;
  localparam logic [1:0] SRC_W    = 2'd1;
  localparam logic [1:0] SRC_U    = 2'd2;
  localparam logic [1:0] SRC_M    = 2'd3;

  ent_t       fifo_q [4];
  ent_t       fifo_d [4];
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       stall_q;

  // New writes compacted in age order W, U, M
  ent_t       nw     [3];
  logic [1:0] nw_src [3];
  ent_t       slot   [2];
  logic [1:0] slot_src [2];

  logic       w_act, w_c, u_c, m_present;
  logic [1:0] wu_n, nn;
  logic [2:0] total;
  logic       g0, g1;
  logic [1:0] ngrant, pop, newgrant, wu_def;
  logic [2:0] base, npush, ptr, k;
  logic       m_granted, m_push, space;

  always_comb begin
    // W/U are only presented while the pipeline is not frozen. Address 0
    // writes complete without consuming a port or a FIFO slot.
    w_act     = !stall_q && wb_valid;
    w_c       = w_act && (wb_addr != 5'd0);
    // U is dropped when it targets the same register as W: the load wins.
    u_c       = !stall_q && upd_valid && (upd_addr != 5'd0) &&
                !(w_act && (upd_addr == wb_addr));
    // M is evaluated as if valid so mc_ready does not depend on mc_valid;
    // M is last in age order, so this cannot disturb other grants.
    m_present = (mc_addr != 5'd0);

    wu_n = {1'b0, w_c} + {1'b0, u_c};
    nn   = wu_n + {1'b0, m_present};

    nw[0]     = w_c ? '{wb_addr, wb_data} :
                (u_c ? '{upd_addr, upd_data} : '{mc_addr, mc_data});
    nw_src[0] = w_c ? SRC_W : (u_c ? SRC_U : SRC_M);
    nw[1]     = (w_c && u_c) ? '{upd_addr, upd_data} : '{mc_addr, mc_data};
    nw_src[1] = (w_c && u_c) ? SRC_U : SRC_M;
    nw[2]     = '{mc_addr, mc_data};
    nw_src[2] = SRC_M;

    // First two candidates: parked entries first, then the new writes
    slot[0]     = (count_q != 3'd0) ? fifo_q[0] : nw[0];
    slot_src[0] = (count_q != 3'd0) ? SRC_FIFO : nw_src[0];
    if (count_q >= 3'd2) begin
      slot[1]     = fifo_q[1];
      slot_src[1] = SRC_FIFO;
    end else if (count_q == 3'd1) begin
      slot[1]     = nw[0];
      slot_src[1] = nw_src[0];
    end else begin
      slot[1]     = nw[1];
      slot_src[1] = nw_src[1];
    end

    total = count_q + {1'b0, nn};
    g0    = (total >= 3'd1);
    // Port 1 is withheld on an address clash so the older write lands alone;
    // nothing younger may skip ahead of it.
    g1    = (total >= 3'd2) && (slot[1].addr != slot[0].addr);

    ngrant   = {1'b0, g0} + {1'b0, g1};
    pop      = (count_q >= {1'b0, ngrant}) ? ngrant : count_q[1:0];
    newgrant = ngrant - pop;
    wu_def   = wu_n - ((newgrant > wu_n) ? wu_n : newgrant);
    base     = count_q - {1'b0, pop};

    m_granted = m_present && (wu_n < newgrant);
    space     = ((base + {1'b0, wu_def}) < 3'd4);
    m_push    = mc_valid && m_present && !m_granted && space;
    mc_ready  = rst_n && (!m_present || m_granted || space);

    wen0   = rst_n && g0 && ((slot_src[0] != SRC_M) || mc_valid);
    waddr0 = slot[0].addr;
    wdata0 = slot[0].data;
    wen1   = rst_n && g1 && ((slot_src[1] != SRC_M) || mc_valid);
    waddr1 = slot[1].addr;
    wdata1 = slot[1].data;

    // Shift out granted entries, then append the ungranted new writes
    for (int i = 0; i < 4; i++) begin
      k = 3'(i) + {1'b0, pop};
      fifo_d[i] = (k < 3'd4) ? fifo_q[k[1:0]] : '0;
    end
    npush = {1'b0, wu_n} + {2'b00, m_push};
    ptr   = base;
    for (int j = 0; j < 3; j++) begin
      if ((3'(j) >= {1'b0, newgrant}) && (3'(j) < npush) && (ptr < 3'd4)) begin
        fifo_d[ptr[1:0]] = nw[j];
        ptr = ptr + 3'd1;
      end
    end
    count_d = ptr;
  end

  // Hazard query; the loop runs oldest to youngest so the youngest match wins
`ifdef RF_WRITE_ARB_FWD_EN
  logic [31:0] fwd0, fwd1;
`endif
  logic        hit0, hit1;

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
`ifdef RF_WRITE_ARB_FWD_EN
    fwd0 = '0;
    fwd1 = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count_q) && (fifo_q[i].addr == raddr0)) begin
        hit0 = 1'b1;
`ifdef RF_WRITE_ARB_FWD_EN
        fwd0 = fifo_q[i].data;
`endif
      end
      if ((3'(i) < count_q) && (fifo_q[i].addr == raddr1)) begin
        hit1 = 1'b1;
`ifdef RF_WRITE_ARB_FWD_EN
        fwd1 = fifo_q[i].data;
`endif
      end
    end
    pend_hit0 = rst_n && hit0 && (raddr0 != 5'd0);
    pend_hit1 = rst_n && hit1 && (raddr1 != 5'd0);
`ifdef RF_WRITE_ARB_FWD_EN
    fwd_data0 = pend_hit0 ? fwd0 : '0;
    fwd_data1 = pend_hit1 ? fwd1 : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 3'd0;
      stall_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      count_q <= count_d;
      // Freezing at two parked writes keeps room for W and U every free cycle
      stall_q <= (count_d >= 3'd2);
      for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign stall_out = stall_q;

endmodule

// File: tb/tb_rf_write_arb.sv
module tb_rf_write_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, upd_valid, mc_valid;
  logic [4:0]  wb_addr, upd_addr, mc_addr, raddr0, raddr1;
  logic [31:0] wb_data, upd_data, mc_data;
  logic        mc_ready, wen0, wen1, pend_hit0, pend_hit1, stall_out;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
`ifdef RF_WRITE_ARB_FWD_EN
  logic [31:0] fwd_data0, fwd_data1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_write_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_ready(mc_ready),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .pend_hit0(pend_hit0), .pend_hit1(pend_hit1),
`ifdef RF_WRITE_ARB_FWD_EN
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
`endif
    .stall_out(stall_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks both write ports; address/data only matter when a write is expected
  task automatic chk_ports(input string tag,
                           input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                           input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    chk({tag, ".wen0"}, {31'd0, wen0}, {31'd0, e0});
    if (e0) begin
      chk({tag, ".waddr0"}, {27'd0, waddr0}, {27'd0, a0});
      chk({tag, ".wdata0"}, wdata0, d0);
    end
    chk({tag, ".wen1"}, {31'd0, wen1}, {31'd0, e1});
    if (e1) begin
      chk({tag, ".waddr1"}, {27'd0, waddr1}, {27'd0, a1});
      chk({tag, ".wdata1"}, wdata1, d1);
    end
    chk({tag, ".count_le4"}, {31'd0, (dut.count_q <= 3'd4)}, 32'd1);
  endtask

  task automatic idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    upd_valid = 0; upd_addr = 0; upd_data = 0;
    mc_valid = 0; mc_addr = 0; mc_data = 0;
    raddr0 = 0; raddr1 = 0;
  endtask

  task automatic set_w(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask
  task automatic set_u(input logic [4:0] a, input logic [31:0] d);
    upd_valid = 1; upd_addr = a; upd_data = d;
  endtask
  task automatic set_m(input logic [4:0] a, input logic [31:0] d);
    mc_valid = 1; mc_addr = a; mc_data = d;
  endtask

  // Advance to the next rising edge and step just past it
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // ---- reset: outputs forced low even with requests driven ----
    idle();
    rst_n = 0;
    set_w(5'd5, 32'h55); set_m(5'd3, 32'h33); raddr0 = 5'd3;
    #2;
    chk_ports("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.mc_ready", {31'd0, mc_ready}, 0);
    chk("rst.stall", {31'd0, stall_out}, 0);
    chk("rst.pend_hit0", {31'd0, pend_hit0}, 0);
    next_cycle();
    chk_ports("rst_edge", 0, 0, 0, 0, 0, 0);
    idle();
    rst_n = 1;
    next_cycle();

    // ---- W(r5) + U(r6), FIFO empty: both written directly ----
    set_w(5'd5, 32'h11); set_u(5'd6, 32'h22); raddr0 = 5'd5;
    @(negedge clk);
    chk_ports("wu_direct", 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    chk("wu_direct.pend0", {31'd0, pend_hit0}, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("wu_direct.stall", {31'd0, stall_out}, 0);
    chk_ports("wu_direct.after", 0, 0, 0, 0, 0, 0);
    next_cycle();

    // ---- W(r7) + U(r7): U dropped ----
    set_w(5'd7, 32'hAA); set_u(5'd7, 32'hBB);
    @(negedge clk);
    chk_ports("same_addr", 1, 5'd7, 32'hAA, 0, 0, 0);
    next_cycle();

    // ---- W(r0) + U(r2): r0 completes silently ----
    idle();
    set_w(5'd0, 32'h99); set_u(5'd2, 32'h33);
    @(negedge clk);
    chk_ports("r0_write", 1, 5'd2, 32'h33, 0, 0, 0);
    next_cycle();

    // ---- W(r4), U(r9), M(r3) together: M deferred ----
    idle();
    set_w(5'd4, 32'h1); set_u(5'd9, 32'h2); set_m(5'd3, 32'h3);
    @(negedge clk);
    chk_ports("wum", 1, 5'd4, 32'h1, 1, 5'd9, 32'h2);
    chk("wum.mc_ready", {31'd0, mc_ready}, 1);
    next_cycle();

    // FIFO {r3}: drains on port 0 with W behind it, U and M are deferred
    idle();
    set_w(5'd10, 32'hA); set_u(5'd11, 32'hB); set_m(5'd12, 32'hC);
    raddr0 = 5'd3; raddr1 = 5'd11;
    @(negedge clk);
    chk_ports("drain_r3", 1, 5'd3, 32'h3, 1, 5'd10, 32'hA);
    chk("drain_r3.pend0", {31'd0, pend_hit0}, 1);
    chk("drain_r3.pend1", {31'd0, pend_hit1}, 0);
    chk("drain_r3.stall", {31'd0, stall_out}, 0);
    chk("drain_r3.mc_ready", {31'd0, mc_ready}, 1);
    next_cycle();

    // ---- FIFO {r11,r12}: stalled, W ignored, two drain at once ----
    idle();
    set_w(5'd13, 32'hD); raddr1 = 5'd12;
    @(negedge clk);
    chk("stall.rise", {31'd0, stall_out}, 1);
    chk("stall.pend1", {31'd0, pend_hit1}, 1);
    chk_ports("stall.drain", 1, 5'd11, 32'hB, 1, 5'd12, 32'hC);
    next_cycle();
    idle();
    @(negedge clk);
    chk("stall.fall", {31'd0, stall_out}, 0);
    chk_ports("stall.w_ignored", 0, 0, 0, 0, 0, 0);
    next_cycle();

    // ---- FIFO {r8,r8}: one write per cycle, younger lands last ----
    set_w(5'd4, 32'h1); set_u(5'd9, 32'h2); set_m(5'd8, 32'h81);
    @(negedge clk);
    chk_ports("r8.setup", 1, 5'd4, 32'h1, 1, 5'd9, 32'h2);
    next_cycle();
    idle();
    set_w(5'd8, 32'h82); set_m(5'd8, 32'h83);
    @(negedge clk);
    chk_ports("r8.clash", 1, 5'd8, 32'h81, 0, 0, 0);
    chk("r8.mc_ready", {31'd0, mc_ready}, 1);
    next_cycle();
    idle();
    raddr0 = 5'd8;
    @(negedge clk);
    chk("r8.stall", {31'd0, stall_out}, 1);
    chk_ports("r8.first", 1, 5'd8, 32'h82, 0, 0, 0);
`ifdef RF_WRITE_ARB_FWD_EN
    chk("r8.fwd0", fwd_data0, 32'h83);
`endif
    next_cycle();
    @(negedge clk);
    chk("r8.stall_fall", {31'd0, stall_out}, 0);
    chk_ports("r8.second", 1, 5'd8, 32'h83, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk_ports("r8.empty", 0, 0, 0, 0, 0, 0);
    chk("r8.pend0", {31'd0, pend_hit0}, 0);
    next_cycle();

    // ---- three parked writes, reset mid-drain ----
    idle();
    set_w(5'd4, 32'h1); set_u(5'd9, 32'h2); set_m(5'd8, 32'hA1);
    next_cycle();
    idle();
    set_w(5'd8, 32'hB2); set_u(5'd9, 32'hC3); set_m(5'd8, 32'hD4);
    @(negedge clk);
    chk_ports("r3e.fill", 1, 5'd8, 32'hA1, 0, 0, 0);
    next_cycle();
    idle();
    raddr0 = 5'd8;
    @(negedge clk);
    chk("r3e.stall", {31'd0, stall_out}, 1);
    chk_ports("r3e.drain", 1, 5'd8, 32'hB2, 1, 5'd9, 32'hC3);
    chk("r3e.pend0", {31'd0, pend_hit0}, 1);
`ifdef RF_WRITE_ARB_FWD_EN
    chk("r3e.fwd0", fwd_data0, 32'hD4);
`endif
    #1;
    rst_n = 0;
    #1;
    chk_ports("r3e.rst", 0, 0, 0, 0, 0, 0);
    chk("r3e.rst_stall", {31'd0, stall_out}, 0);
    chk("r3e.rst_pend0", {31'd0, pend_hit0}, 0);
    chk("r3e.rst_mc_ready", {31'd0, mc_ready}, 0);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    chk_ports("r3e.post", 0, 0, 0, 0, 0, 0);
    chk("r3e.post_pend0", {31'd0, pend_hit0}, 0);
    chk("r3e.post_stall", {31'd0, stall_out}, 0);
    next_cycle();
    @(negedge clk);
    chk_ports("r3e.post2", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
